// File: rtl/uart_hex_pkg.sv
// Shared constants, FSM state type and ASCII character-class helpers for the hex word packer.
package uart_hex_pkg;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {IDLE, ACCUM, DROP} state_e;

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Only meaningful when is_hex(c); letters share the low nibble 1..6 in both cases.
  function automatic logic [3:0] hex_nibble(input logic [7:0] c);
    if (c <= 8'h39) return c[3:0];
    else            return c[3:0] + 4'd9;
  endfunction

  function automatic logic is_delim(input logic [7:0] c);
    return (c == ASCII_SP) || (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous show-ahead FIFO; a push while full is dropped unless a pop frees a slot that cycle.
module uart_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == (PtrW+1)'(DEPTH));
  assign w_pop    = pop && !empty;
  assign w_push   = push && (!full || w_pop);
  assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_hex_word_packer.sv
// Packs UART hex characters MSB-first into words and buffers them for a valid/ready consumer.
// Define UART_HEX_PACKER_ECHO_EN to echo each cleanly received character back to the UART.
module uart_hex_word_packer #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  received,
  input  logic [7:0]            rx_byte,
  input  logic                  recv_error,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  char_error,
  output logic                  overflow,
`ifdef UART_HEX_PACKER_ECHO_EN
  input  logic                  tx_ready,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
`endif
  output logic                  busy
);

  import uart_hex_pkg::*;

  localparam int unsigned N    = WORD_WIDTH / 4;
  localparam int unsigned CntW = $clog2(N + 1);

  state_e                r_state;
  logic [WORD_WIDTH-1:0] r_acc;
  logic [CntW-1:0]       r_cnt;
  logic                  r_char_error;
  logic                  r_overflow;

  logic                  w_hex;
  logic                  w_delim;
  logic                  w_illegal;
  logic [3:0]            w_nib;
  logic [CntW-1:0]       w_cnt_inc;
  logic                  w_word_done;
  logic [WORD_WIDTH-1:0] w_shift;
  logic                  w_push;
  logic [WORD_WIDTH-1:0] w_push_data;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  // A framing error overrides whatever byte came with it.
  assign w_hex       = !recv_error && is_hex(rx_byte);
  assign w_delim     = !recv_error && is_delim(rx_byte);
  assign w_illegal   = !w_hex && !w_delim;
  assign w_nib       = hex_nibble(rx_byte);
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_word_done = (w_cnt_inc == CntW'(N));
  assign w_shift     = (r_acc << 4) | WORD_WIDTH'(w_nib);

  always_comb begin
    w_push      = 1'b0;
    w_push_data = w_shift;
    if (received) begin
      case (r_state)
        IDLE:    w_push = w_hex && (N == 1);
        ACCUM: begin
          if (w_hex) begin
            w_push = w_word_done;
          end else if (w_delim) begin
            w_push      = 1'b1;
            w_push_data = r_acc;
          end
        end
        default: w_push = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_char_error <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_char_error <= 1'b0;
      // Dropped push: FIFO full and no pop freeing a slot this cycle.
      r_overflow   <= w_push && w_fifo_full && !(word_ready && !w_fifo_empty);
      if (received) begin
        unique case (r_state)
          IDLE: begin
            if (w_hex && (N != 1)) begin
              r_acc   <= WORD_WIDTH'(w_nib);
              r_cnt   <= CntW'(1);
              r_state <= ACCUM;
            end else if (w_illegal) begin
              r_char_error <= 1'b1;
              r_state      <= DROP;
            end
          end
          ACCUM: begin
            if (w_hex && !w_word_done) begin
              r_acc <= w_shift;
              r_cnt <= w_cnt_inc;
            end else begin
              r_acc   <= '0;
              r_cnt   <= '0;
              r_state <= IDLE;
              if (w_illegal) begin
                r_char_error <= 1'b1;
                r_state      <= DROP;
              end
            end
          end
          DROP: begin
            if (w_delim) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  uart_word_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (word_ready),
    .pop_data  (word_out),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  assign word_valid = !w_fifo_empty;
  assign char_error = r_char_error;
  assign overflow   = r_overflow;
  assign busy       = (r_state != IDLE);

`ifdef UART_HEX_PACKER_ECHO_EN
  logic       r_echo_pend;
  logic [7:0] r_echo_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_echo_pend <= 1'b0;
      r_echo_byte <= '0;
    end else begin
      r_echo_pend <= received && !recv_error;
      if (received && !recv_error) r_echo_byte <= rx_byte;
    end
  end

  // No queue: an echo that meets tx_ready=0 is lost.
  assign transmit = r_echo_pend && tx_ready;
  assign tx_byte  = r_echo_byte;
`endif

endmodule

// File: tb/tb_uart_hex_word_packer.sv
// Directed self-checking bench for uart_hex_word_packer (WORD_WIDTH=32, FIFO_DEPTH=4).
module tb_uart_hex_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        received = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        recv_error = 1'b0;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        char_error;
  logic        overflow;
  logic        busy;
`ifdef UART_HEX_PACKER_ECHO_EN
  logic        tx_ready = 1'b1;
  logic        transmit;
  logic [7:0]  tx_byte;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_cerr   = 0;
  int n_ovf    = 0;
  int cerr0;
  int ovf0;
  logic [31:0] got[$];

  always #5 clk = ~clk;

  uart_hex_word_packer #(
    .WORD_WIDTH (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .received   (received),
    .rx_byte    (rx_byte),
    .recv_error (recv_error),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .char_error (char_error),
    .overflow   (overflow),
`ifdef UART_HEX_PACKER_ECHO_EN
    .tx_ready   (tx_ready),
    .transmit   (transmit),
    .tx_byte    (tx_byte),
`endif
    .busy       (busy)
  );

  // Inputs change at posedge+1, so the negedge sees stable values.
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) got.push_back(word_out);
    if (char_error) n_cerr++;
    if (overflow) n_ovf++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] c, input logic err, input logic rdy);
    @(posedge clk);
    #1;
    received   = 1'b1;
    rx_byte    = c;
    recv_error = err;
    word_ready = rdy;
    @(posedge clk);
    #1;
    received   = 1'b0;
    recv_error = 1'b0;
  endtask

  task automatic send_str(input string s, input logic rdy);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b0, rdy);
  endtask

  initial begin
    // Reset values
    idle(3);
    chk("rst_word_out", word_out, 32'h0);
    chk("rst_word_valid", {31'b0, word_valid}, 32'h0);
    chk("rst_char_error", {31'b0, char_error}, 32'h0);
    chk("rst_overflow", {31'b0, overflow}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    idle(1);

    // Full word, 1-cycle latency after the last nibble
    got.delete();
    send("D", 1'b0, 1'b1);
    chk("deadbeef_busy_mid", {31'b0, busy}, 32'h1);
    send_str("EADBEE", 1'b1);
    chk("deadbeef_valid_early", {31'b0, word_valid}, 32'h0);
    send("F", 1'b0, 1'b1);
    chk("deadbeef_valid", {31'b0, word_valid}, 32'h1);
    chk("deadbeef_word", word_out, 32'hDEADBEEF);
    chk("deadbeef_busy_end", {31'b0, busy}, 32'h0);
    idle(1);
    chk("deadbeef_popped", {31'b0, word_valid}, 32'h0);

    // Partial words closed by delimiters, lower-case hex
    got.delete();
    cerr0 = n_cerr;
    send_str("ab 12\r", 1'b1);
    idle(3);
    chk("ab12_count", got.size(), 32'd2);
    chk("ab12_w0", got[0], 32'h000000AB);
    chk("ab12_w1", got[1], 32'h00000012);
    chk("ab12_no_cerr", n_cerr - cerr0, 32'd0);

    // Illegal character: drop until delimiter
    got.delete();
    cerr0 = n_cerr;
    send_str("12", 1'b1);
    send("G", 1'b0, 1'b1);
    chk("g_cerr_pulse", {31'b0, char_error}, 32'h1);
    chk("g_busy_drop", {31'b0, busy}, 32'h1);
    idle(1);
    chk("g_cerr_clear", {31'b0, char_error}, 32'h0);
    send_str("4 ", 1'b1);
    chk("g_busy_idle", {31'b0, busy}, 32'h0);
    send_str("77\n", 1'b1);
    idle(3);
    chk("g_count", got.size(), 32'd1);
    chk("g_word", got[0], 32'h00000077);
    chk("g_cerr_total", n_cerr - cerr0, 32'd1);

    // Framing error mid-word
    got.delete();
    cerr0 = n_cerr;
    send_str("5A", 1'b1);
    send("1", 1'b1, 1'b1);
    chk("rxerr_cerr", {31'b0, char_error}, 32'h1);
    chk("rxerr_busy", {31'b0, busy}, 32'h1);
    send_str("3 ", 1'b1);
    idle(3);
    chk("rxerr_no_word", got.size(), 32'd0);
    chk("rxerr_busy_end", {31'b0, busy}, 32'h0);
    chk("rxerr_cerr_total", n_cerr - cerr0, 32'd1);

    // Overflow: 5 words into a 4-deep FIFO with no consumer
    got.delete();
    ovf0 = n_ovf;
    send_str("11111111222222223333333344444444", 1'b0);
    chk("ovf_valid_full", {31'b0, word_valid}, 32'h1);
    chk("ovf_head", word_out, 32'h11111111);
    chk("ovf_none_yet", n_ovf - ovf0, 32'd0);
    send_str("55555555", 1'b0);
    chk("ovf_pulse", {31'b0, overflow}, 32'h1);
    chk("ovf_busy", {31'b0, busy}, 32'h0);
    idle(1);
    chk("ovf_pulse_clear", {31'b0, overflow}, 32'h0);
    chk("ovf_head_stable", word_out, 32'h11111111);
    word_ready = 1'b1;
    idle(6);
    chk("ovf_count", got.size(), 32'd4);
    chk("ovf_w0", got[0], 32'h11111111);
    chk("ovf_w1", got[1], 32'h22222222);
    chk("ovf_w2", got[2], 32'h33333333);
    chk("ovf_w3", got[3], 32'h44444444);
    chk("ovf_total", n_ovf - ovf0, 32'd1);
    chk("ovf_drained", {31'b0, word_valid}, 32'h0);

    // Full FIFO with a pop in the same cycle as the completing push
    got.delete();
    ovf0 = n_ovf;
    send_str("AAAAAAAABBBBBBBBCCCCCCCCDDDDDDDDEEEEEEE", 1'b0);
    send("E", 1'b0, 1'b1);
    idle(6);
    chk("simul_no_ovf", n_ovf - ovf0, 32'd0);
    chk("simul_count", got.size(), 32'd5);
    chk("simul_w0", got[0], 32'hAAAAAAAA);
    chk("simul_w3", got[3], 32'hDDDDDDDD);
    chk("simul_w4", got[4], 32'hEEEEEEEE);

    // Reset mid-word with a word waiting
    got.delete();
    send_str("CAFEF00D12", 1'b0);
    chk("prerst_valid", {31'b0, word_valid}, 32'h1);
    chk("prerst_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst_word_out", word_out, 32'h0);
    chk("midrst_valid", {31'b0, word_valid}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_cerr", {31'b0, char_error}, 32'h0);
    chk("midrst_ovf", {31'b0, overflow}, 32'h0);
    send_str("9 ", 1'b1);
    idle(3);
    chk("postrst_count", got.size(), 32'd1);
    chk("postrst_word", got[0], 32'h00000009);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
